// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter: DIGITS-digit modulo-(DIGIT_MAX+1) cascade counter with up/down, enable, load.
// Optional enable prescaler when BCD_CASCADE_COUNTER_PRESCALER_EN is defined.
`default_nettype none

module bcd_cascade_counter #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_MAX = 9,
  parameter int PRESCALE  = 1000
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic                  in_enable,
  input  logic                  in_up,
  input  logic                  in_load,
  input  logic [4*DIGITS-1:0]   in_load_value,
  output logic [4*DIGITS-1:0]   out_count,
  output logic                  out_terminal,
  output logic                  out_carry
);

  localparam logic [3:0] MAX_D = 4'(DIGIT_MAX);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry_q, carry_d;
  logic                step;
  logic                all_max, all_zero;
  logic                lower_max, lower_zero;
  logic [3:0]          dig;

`ifdef BCD_CASCADE_COUNTER_PRESCALER_EN
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            ps_tick;

  assign ps_tick = (ps_q == PS_LAST);
  assign step    = in_enable & ps_tick;

  always_comb begin
    ps_d = ps_q;
    if (in_load) begin
      ps_d = '0;
    end else if (in_enable) begin
      ps_d = ps_tick ? '0 : ps_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  logic prescale_unused;
  assign prescale_unused = (PRESCALE >= 1);
  assign step            = in_enable;
`endif

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      all_max  = all_max  & (count_q[4*k +: 4] == MAX_D);
      all_zero = all_zero & (count_q[4*k +: 4] == 4'd0);
    end
  end

  // Direction is combinational so a change of in_up applies to the same cycle's step.
  assign out_terminal = in_up ? all_max : all_zero;

  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    lower_max  = 1'b1;
    lower_zero = 1'b1;
    dig        = 4'd0;
    if (in_load) begin
      for (int k = 0; k < DIGITS; k++) begin
        dig = in_load_value[4*k +: 4];
        count_d[4*k +: 4] = (dig > MAX_D) ? 4'd0 : dig;
      end
    end else if (step) begin
      carry_d = out_terminal;
      for (int k = 0; k < DIGITS; k++) begin
        dig = count_q[4*k +: 4];
        if (in_up) begin
          if (lower_max) begin
            count_d[4*k +: 4] = (dig == MAX_D) ? 4'd0 : dig + 4'd1;
          end
        end else begin
          if (lower_zero) begin
            count_d[4*k +: 4] = (dig == 4'd0) ? MAX_D : dig - 4'd1;
          end
        end
        lower_max  = lower_max  & (dig == MAX_D);
        lower_zero = lower_zero & (dig == 4'd0);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign out_count = count_q;
  assign out_carry = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_cascade_counter.sv
// Directed self-checking bench for bcd_cascade_counter (2-digit BCD, 1-digit hex, optional prescaled).
`default_nettype none

module tb_bcd_cascade_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, ld;
  logic [7:0] ld_val, cnt;
  logic       term, carry;

  logic       h_en, h_up, h_ld;
  logic [3:0] h_ld_val, h_cnt;
  logic       h_term, h_carry;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(2), .DIGIT_MAX(9), .PRESCALE(1)) u_dut (
    .in_clk(clk), .in_reset(rst), .in_enable(en), .in_up(up), .in_load(ld),
    .in_load_value(ld_val), .out_count(cnt), .out_terminal(term), .out_carry(carry)
  );

  bcd_cascade_counter #(.DIGITS(1), .DIGIT_MAX(15), .PRESCALE(1)) u_hex (
    .in_clk(clk), .in_reset(rst), .in_enable(h_en), .in_up(h_up), .in_load(h_ld),
    .in_load_value(h_ld_val), .out_count(h_cnt), .out_terminal(h_term), .out_carry(h_carry)
  );

`ifdef BCD_CASCADE_COUNTER_PRESCALER_EN
  logic       p_en, p_ld;
  logic [7:0] p_ld_val, p_cnt;
  logic       p_term, p_carry;

  bcd_cascade_counter #(.DIGITS(2), .DIGIT_MAX(9), .PRESCALE(3)) u_ps (
    .in_clk(clk), .in_reset(rst), .in_enable(p_en), .in_up(1'b1), .in_load(p_ld),
    .in_load_value(p_ld_val), .out_count(p_cnt), .out_terminal(p_term), .out_carry(p_carry)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle outputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; ld_val = 8'h00;
    h_en = 1'b0; h_up = 1'b1; h_ld = 1'b0; h_ld_val = 4'h0;
`ifdef BCD_CASCADE_COUNTER_PRESCALER_EN
    p_en = 1'b0; p_ld = 1'b0; p_ld_val = 8'h00;
`endif
    tick();
    tick();
    check("reset_count", 32'(cnt), 32'h00);
    check("reset_carry", 32'(carry), 32'h0);
    check("reset_term_up", 32'(term), 32'h0);
    up = 1'b0;
    #1;
    check("reset_term_down", 32'(term), 32'h1);

    // Full BCD sweep 00..99 then wrap.
    rst = 1'b0; up = 1'b1; en = 1'b1;
    for (int i = 1; i < 100; i++) begin
      tick();
      check("sweep_count", 32'(cnt), 32'(((i / 10) << 4) | (i % 10)));
      if (i == 50) check("sweep_carry_mid", 32'(carry), 32'h0);
    end
    check("sweep_term_at_99", 32'(term), 32'h1);
    tick();
    check("wrap_count", 32'(cnt), 32'h00);
    check("wrap_carry", 32'(carry), 32'h1);
    en = 1'b0;
    tick();
    check("wrap_carry_drop", 32'(carry), 32'h0);

    // Down-count borrow and full down wrap.
    ld = 1'b1; ld_val = 8'h10;
    tick();
    check("load_10", 32'(cnt), 32'h10);
    ld = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("down_borrow", 32'(cnt), 32'h09);
    check("down_borrow_carry", 32'(carry), 32'h0);
    ld = 1'b1; ld_val = 8'h00; en = 1'b0;
    tick();
    check("load_00", 32'(cnt), 32'h00);
    check("term_down_00", 32'(term), 32'h1);
    ld = 1'b0; en = 1'b1;
    tick();
    check("down_wrap_count", 32'(cnt), 32'h99);
    check("down_wrap_carry", 32'(carry), 32'h1);
    en = 1'b0;
    tick();
    check("down_wrap_hold", 32'(cnt), 32'h99);
    check("down_wrap_carry_drop", 32'(carry), 32'h0);

    // Load clamping and load priority over enable.
    ld = 1'b1; ld_val = 8'hAF; en = 1'b1; up = 1'b1;
    tick();
    check("load_clamp_AF", 32'(cnt), 32'h00);
    ld_val = 8'h3C;
    tick();
    check("load_clamp_3C", 32'(cnt), 32'h30);
    ld_val = 8'h42;
    tick();
    check("load_beats_enable", 32'(cnt), 32'h42);

    // Hold with enable low, then reset overrides enable.
    ld_val = 8'h56;
    tick();
    ld = 1'b0;
    tick();
    check("up_to_57", 32'(cnt), 32'h57);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_count", 32'(cnt), 32'h57);
      check("hold_carry", 32'(carry), 32'h0);
    end
    rst = 1'b1; en = 1'b1;
    tick();
    check("reset_over_enable", 32'(cnt), 32'h00);
    rst = 1'b0; en = 1'b0;

    // Reset beats a pending wrap carry.
    ld = 1'b1; ld_val = 8'h99;
    tick();
    ld = 1'b0; rst = 1'b1; en = 1'b1; up = 1'b1;
    tick();
    check("reset_over_wrap_count", 32'(cnt), 32'h00);
    check("reset_over_wrap_carry", 32'(carry), 32'h0);
    rst = 1'b0; en = 1'b0;

    // Single hex digit: wrap and direction toggling every cycle.
    h_ld = 1'b1; h_ld_val = 4'hF;
    tick();
    h_ld = 1'b0; h_en = 1'b1; h_up = 1'b1;
    tick();
    check("hex_wrap_count", 32'(h_cnt), 32'h0);
    check("hex_wrap_carry", 32'(h_carry), 32'h1);
    for (int i = 0; i < 4; i++) begin
      h_up = ~h_up;
      tick();
      check("hex_toggle_count", 32'(h_cnt), h_up ? 32'h0 : 32'hF);
      check("hex_toggle_carry", 32'(h_carry), 32'h1);
    end
    h_en = 1'b0;
    tick();
    check("hex_carry_drop", 32'(h_carry), 32'h0);

`ifdef BCD_CASCADE_COUNTER_PRESCALER_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; p_en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("ps_count", 32'(p_cnt), 32'(c / 3));
    end
    p_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; p_en = 1'b1;
    tick();
    p_ld = 1'b1; p_ld_val = 8'h05;
    tick();
    check("ps_load", 32'(p_cnt), 32'h05);
    p_ld = 1'b0;
    tick();
    tick();
    check("ps_restart_hold", 32'(p_cnt), 32'h05);
    tick();
    check("ps_restart_step", 32'(p_cnt), 32'h06);
    p_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
